// File: rtl/mvm_job_sched_if.sv
// mvm_job_sched_if
//   Bundles the signals around the mvm job scheduler into one interface.
//   Host job port: i_job_valid/o_job_ready plus descriptor fields, o_job_err.
//   mvm engine port: o_mvm_start and held descriptor outputs; i_mvm_busy,
//   i_mvm_valid and i_mvm_result coming back from the engine.
//   Result port: o_res_valid/i_res_ready/o_res_data, plus o_overflow and o_idle.
//   modport slave  : the scheduler's view.
//   modport master : the surrounding host / engine / consumer view.
interface mvm_job_sched_if #(
    parameter int VEC_ADDRW  = 8,
    parameter int MAT_ADDRW  = 9,
    parameter int OWIDTH     = 32,
    parameter int NUM_OLANES = 8
);
    logic                           i_job_valid;
    logic                           o_job_ready;
    logic [VEC_ADDRW-1:0]           i_job_vec_start;
    logic [VEC_ADDRW:0]             i_job_vec_words;
    logic [MAT_ADDRW-1:0]           i_job_mat_start;
    logic [MAT_ADDRW:0]             i_job_mat_rows;
    logic                           o_job_err;
    logic                           o_mvm_start;
    logic [VEC_ADDRW-1:0]           o_mvm_vec_start;
    logic [VEC_ADDRW:0]             o_mvm_vec_words;
    logic [MAT_ADDRW-1:0]           o_mvm_mat_start;
    logic [MAT_ADDRW:0]             o_mvm_mat_rows;
    logic                           i_mvm_busy;
    logic                           i_mvm_valid;
    logic [NUM_OLANES*OWIDTH-1:0]   i_mvm_result;
    logic                           o_res_valid;
    logic                           i_res_ready;
    logic [NUM_OLANES*OWIDTH-1:0]   o_res_data;
    logic                           o_overflow;
    logic                           o_idle;

    modport slave (
        input  i_job_valid, i_job_vec_start, i_job_vec_words, i_job_mat_start, i_job_mat_rows,
        input  i_mvm_busy, i_mvm_valid, i_mvm_result, i_res_ready,
        output o_job_ready, o_job_err, o_mvm_start, o_mvm_vec_start, o_mvm_vec_words,
        output o_mvm_mat_start, o_mvm_mat_rows, o_res_valid, o_res_data, o_overflow, o_idle
    );

    modport master (
        output i_job_valid, i_job_vec_start, i_job_vec_words, i_job_mat_start, i_job_mat_rows,
        output i_mvm_busy, i_mvm_valid, i_mvm_result, i_res_ready,
        input  o_job_ready, o_job_err, o_mvm_start, o_mvm_vec_start, o_mvm_vec_words,
        input  o_mvm_mat_start, o_mvm_mat_rows, o_res_valid, o_res_data, o_overflow, o_idle
    );
endinterface

// File: rtl/mvm_job_sched.sv
// mvm_job_sched
//   Job scheduler in front of the mvm engine. Host descriptors are buffered in
//   a job FIFO and issued one at a time (one-cycle start pulse, fields held
//   until the next issue). Every mvm result beat is captured in a result FIFO
//   and streamed out over valid/ready. Since mvm results cannot be stalled, a
//   job only issues when the result FIFO has credits for all of its beats.
// Ports
//   clk, rst : clock, synchronous active-high reset
//   bus      : mvm_job_sched_if.slave (host job port, mvm port, result port)
//
// state       | meaning
// S_IDLE      | may drop an illegal head or issue a legal head with enough credits
// S_WAIT_BUSY | job started, waiting for mvm busy to rise
// S_RUN       | mvm working, waiting for busy to fall
module mvm_job_sched #(
    parameter int VEC_ADDRW  = 8,
    parameter int MAT_ADDRW  = 9,
    parameter int OWIDTH     = 32,
    parameter int NUM_OLANES = 8,
    parameter int JOB_DEPTH  = 4,
    parameter int RES_DEPTH  = 16
) (
    input  logic            clk,
    input  logic            rst,
    mvm_job_sched_if.slave  bus
);
    localparam int JPW = $clog2(JOB_DEPTH);
    localparam int RPW = $clog2(RES_DEPTH);
    localparam int CW  = RPW + 1;
    localparam int RWW = MAT_ADDRW + 1;
    localparam int DW  = NUM_OLANES * OWIDTH;
    localparam logic [RWW-1:0] MAX_ROWS = RWW'(RES_DEPTH);
    localparam logic [CW-1:0]  CRED_MAX = CW'(RES_DEPTH);

    typedef struct packed {
        logic [VEC_ADDRW-1:0] vec_start;
        logic [VEC_ADDRW:0]   vec_words;
        logic [MAT_ADDRW-1:0] mat_start;
        logic [RWW-1:0]       mat_rows;
    } job_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_RUN} state_t;

    state_t         state_q, state_d;
    job_t           job_mem [JOB_DEPTH];
    logic [JPW:0]   job_wr_q, job_rd_q;
    logic [DW-1:0]  res_mem [RES_DEPTH];
    logic [RPW:0]   res_wr_q, res_rd_q;
    logic [CW-1:0]  credits_q, credits_d;
    logic           start_q, err_q, ovf_q;
    job_t           issued_q;

    job_t           job_in, job_head;
    logic           job_empty, job_full, job_push, job_pop;
    logic           head_illegal, issue, drop;
    logic           res_empty, res_full, res_push, res_pop;
    logic [CW-1:0]  debit;
    logic [CW:0]    cred_sum;

    assign job_in    = {bus.i_job_vec_start, bus.i_job_vec_words, bus.i_job_mat_start, bus.i_job_mat_rows};
    assign job_empty = (job_wr_q == job_rd_q);
    assign job_full  = (job_wr_q[JPW] != job_rd_q[JPW]) && (job_wr_q[JPW-1:0] == job_rd_q[JPW-1:0]);
    assign job_push  = bus.i_job_valid && !job_full;
    assign job_head  = job_mem[job_rd_q[JPW-1:0]];
    assign head_illegal = (job_head.mat_rows == '0) || (job_head.vec_words == '0)
                          || (job_head.mat_rows > MAX_ROWS);

    assign res_empty = (res_wr_q == res_rd_q);
    assign res_full  = (res_wr_q[RPW] != res_rd_q[RPW]) && (res_wr_q[RPW-1:0] == res_rd_q[RPW-1:0]);
    assign res_pop   = !res_empty && bus.i_res_ready;
    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    assign res_push  = bus.i_mvm_valid && (!res_full || res_pop);

    always_comb begin
        state_d = state_q;
        job_pop = 1'b0;
        issue   = 1'b0;
        drop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!job_empty) begin
                    if (head_illegal) begin
                        job_pop = 1'b1;
                        drop    = 1'b1;
                    end else if (RWW'(credits_q) >= job_head.mat_rows) begin
                        job_pop = 1'b1;
                        issue   = 1'b1;
                        state_d = S_WAIT_BUSY;
                    end
                end
            end
            S_WAIT_BUSY: if (bus.i_mvm_busy) state_d = S_RUN;
            S_RUN:       if (!bus.i_mvm_busy) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Issue only happens with credits >= rows, so the sum never goes negative;
    // the clamp covers beats that arrive without a matching debit.
    always_comb begin
        debit     = issue ? job_head.mat_rows[CW-1:0] : '0;
        cred_sum  = {1'b0, credits_q} - {1'b0, debit} + {{CW{1'b0}}, res_pop};
        credits_d = (cred_sum > {1'b0, CRED_MAX}) ? CRED_MAX : cred_sum[CW-1:0];
    end

    always_ff @(posedge clk) begin
        if (job_push) job_mem[job_wr_q[JPW-1:0]] <= job_in;
        if (res_push) res_mem[res_wr_q[RPW-1:0]] <= bus.i_mvm_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            job_wr_q  <= '0;
            job_rd_q  <= '0;
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            credits_q <= CRED_MAX;
            start_q   <= 1'b0;
            issued_q  <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (job_push) job_wr_q <= job_wr_q + (JPW+1)'(1);
            if (job_pop)  job_rd_q <= job_rd_q + (JPW+1)'(1);
            if (res_push) res_wr_q <= res_wr_q + (RPW+1)'(1);
            if (res_pop)  res_rd_q <= res_rd_q + (RPW+1)'(1);
            credits_q <= credits_d;
            start_q   <= issue;
            if (issue) issued_q <= job_head;
            err_q     <= drop;
            if (bus.i_mvm_valid && !res_push) ovf_q <= 1'b1;
        end
    end

    assign bus.o_job_ready     = !job_full;
    assign bus.o_job_err       = err_q;
    assign bus.o_mvm_start     = start_q;
    assign bus.o_mvm_vec_start = issued_q.vec_start;
    assign bus.o_mvm_vec_words = issued_q.vec_words;
    assign bus.o_mvm_mat_start = issued_q.mat_start;
    assign bus.o_mvm_mat_rows  = issued_q.mat_rows;
    assign bus.o_res_valid     = !res_empty;
    assign bus.o_res_data      = res_mem[res_rd_q[RPW-1:0]];
    assign bus.o_overflow      = ovf_q;
    assign bus.o_idle          = (state_q == S_IDLE) && job_empty && res_empty;
endmodule

// File: tb/tb_mvm_job_sched.sv
// tb_mvm_job_sched
//   Drives mvm_job_sched through an interface instance, plays a simple mvm
//   engine, and compares every cycle against a queue-based model of the
//   scheduler. Directed scenarios add literal expectations on top.
module tb_mvm_job_sched;
    localparam int VA = 8, MA = 9, OW = 32, NL = 8, JD = 4, RD = 16;
    localparam int RW = NL * OW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mvm_job_sched_if #(.VEC_ADDRW(VA), .MAT_ADDRW(MA), .OWIDTH(OW), .NUM_OLANES(NL)) bus ();

    mvm_job_sched #(.VEC_ADDRW(VA), .MAT_ADDRW(MA), .OWIDTH(OW), .NUM_OLANES(NL),
                    .JOB_DEPTH(JD), .RES_DEPTH(RD)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { int vs; int vw; int ms; int mr; } mjob_t;

    // Model: job queue, result queue, credits, engine phase
    // (0: ready to issue, 1: started and waiting for busy, 2: engine running).
    mjob_t          jq[$];
    logic [RW-1:0]  rq[$];
    int             credits, phase;
    bit             m_start, m_err, m_ovf;
    int             m_vs, m_vw, m_ms, m_mr;

    int n_tests = 0, n_fail = 0;
    int starts = 0, errs = 0, pops = 0;

    // Engine stand-in
    int mvm_wait = 0, mvm_beats = 0, busy_dly = 2, fv_cnt = 0, p_ready = 100;
    bit mvm_active = 0, hold_busy = 0, force_valid = 0;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] rnd_beat();
        logic [RW-1:0] v;
        for (int i = 0; i < NL; i++) v[i*OW +: OW] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        jq.delete();
        rq.delete();
        credits = RD; phase = 0;
        m_start = 0; m_err = 0; m_ovf = 0;
        m_vs = 0; m_vw = 0; m_ms = 0; m_mr = 0;
        mvm_wait = 0; mvm_beats = 0; mvm_active = 0;
    endtask

    task automatic mvm_drive();
        bus.i_mvm_valid  = 1'b0;
        bus.i_mvm_result = '0;
        if (mvm_wait > 0) begin
            mvm_wait--;
            if (mvm_wait == 0) mvm_active = 1;
        end
        bus.i_mvm_busy = mvm_active;
        if (mvm_active && !hold_busy) begin
            if (mvm_beats > 0) begin
                if ($urandom_range(3) != 0) begin
                    bus.i_mvm_valid  = 1'b1;
                    bus.i_mvm_result = rnd_beat();
                    mvm_beats--;
                end
            end else begin
                bus.i_mvm_busy = 1'b0;
                mvm_active = 0;
            end
        end
        if (force_valid) begin
            fv_cnt++;
            bus.i_mvm_valid  = 1'b1;
            bus.i_mvm_result = {NL{32'(fv_cnt)}};
        end
        if (bus.o_mvm_start) begin
            mvm_beats = int'(bus.o_mvm_mat_rows);
            mvm_wait  = busy_dly;
        end
    endtask

    task automatic check();
        chk("job_ready", bus.o_job_ready, jq.size() < JD);
        chk("res_valid", bus.o_res_valid, rq.size() > 0);
        if (rq.size() > 0) chk("res_data", bus.o_res_data, rq[0]);
        chk("mvm_start", bus.o_mvm_start, m_start);
        chk("vec_start", bus.o_mvm_vec_start, m_vs);
        chk("vec_words", bus.o_mvm_vec_words, m_vw);
        chk("mat_start", bus.o_mvm_mat_start, m_ms);
        chk("mat_rows", bus.o_mvm_mat_rows, m_mr);
        chk("job_err", bus.o_job_err, m_err);
        chk("overflow", bus.o_overflow, m_ovf);
        chk("idle", bus.o_idle, phase == 0 && jq.size() == 0 && rq.size() == 0);
        chk("credits", dut.credits_q, credits);
        if (bus.o_mvm_start) starts++;
        if (bus.o_job_err) errs++;
        if (bus.o_res_valid && bus.i_res_ready) pops++;
    endtask

    task automatic model_next();
        bit    rpop, jpush;
        int    debit;
        mjob_t h;
        if (rst) begin
            model_reset();
            return;
        end
        rpop  = rq.size() > 0 && bus.i_res_ready;
        jpush = bus.i_job_valid && jq.size() < JD;
        debit = 0;
        m_start = 0;
        m_err = 0;
        case (phase)
            0: if (jq.size() > 0) begin
                h = jq[0];
                if (h.mr == 0 || h.vw == 0 || h.mr > RD) begin
                    void'(jq.pop_front());
                    m_err = 1;
                end else if (credits >= h.mr) begin
                    void'(jq.pop_front());
                    m_start = 1;
                    m_vs = h.vs; m_vw = h.vw; m_ms = h.ms; m_mr = h.mr;
                    debit = h.mr;
                    phase = 1;
                end
            end
            1: if (bus.i_mvm_busy) phase = 2;
            default: if (!bus.i_mvm_busy) phase = 0;
        endcase
        credits = credits - debit + int'(rpop);
        if (credits > RD) credits = RD;
        if (rpop) void'(rq.pop_front());
        if (bus.i_mvm_valid) begin
            if (rq.size() < RD) rq.push_back(bus.i_mvm_result);
            else m_ovf = 1;
        end
        if (jpush) begin
            h.vs = int'(bus.i_job_vec_start); h.vw = int'(bus.i_job_vec_words);
            h.ms = int'(bus.i_job_mat_start); h.mr = int'(bus.i_job_mat_rows);
            jq.push_back(h);
        end
    endtask

    // Called at a falling edge with this cycle's host inputs already set.
    task automatic step();
        bus.i_res_ready = ($urandom_range(99) < p_ready);
        mvm_drive();
        check();
        model_next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_job(input int vs, input int vw, input int ms, input int mr);
        bus.i_job_valid     = 1'b1;
        bus.i_job_vec_start = VA'(vs);
        bus.i_job_vec_words = (VA+1)'(vw);
        bus.i_job_mat_start = MA'(ms);
        bus.i_job_mat_rows  = (MA+1)'(mr);
    endtask

    task automatic push_job(input int vs, input int vw, input int ms, input int mr);
        bit done = 0;
        set_job(vs, vw, ms, mr);
        for (int i = 0; i < 200 && !done; i++) begin
            done = bus.o_job_ready;
            step();
        end
        bus.i_job_valid = 1'b0;
        chk("push_timeout", done, 1);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_idle(input int limit);
        bit ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            if (bus.o_idle) ok = 1;
            else step();
        end
        chk("idle_timeout", ok, 1);
    endtask

    initial begin
        logic [4:0] cnt5;
        rst = 1'b1;
        bus.i_job_valid = 1'b0;
        bus.i_job_vec_start = '0; bus.i_job_vec_words = '0;
        bus.i_job_mat_start = '0; bus.i_job_mat_rows = '0;
        bus.i_mvm_busy = 1'b0; bus.i_mvm_valid = 1'b0; bus.i_mvm_result = '0;
        bus.i_res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;

        // reset state
        chk("rst_job_ready", bus.o_job_ready, 1);
        chk("rst_res_valid", bus.o_res_valid, 0);
        chk("rst_idle", bus.o_idle, 1);
        chk("rst_start", bus.o_mvm_start, 0);
        chk("rst_credits", dut.credits_q, 16);

        // 1: single job, start two cycles after the push
        pops = 0;
        set_job(0, 4, 0, 2);
        step();
        bus.i_job_valid = 1'b0;
        step();
        chk("t1_start_t2", bus.o_mvm_start, 1);
        chk("t1_words", bus.o_mvm_vec_words, 4);
        chk("t1_rows", bus.o_mvm_mat_rows, 2);
        chk("t1_credits_debit", dut.credits_q, 14);
        wait_idle(100);
        chk("t1_pops", pops, 2);
        chk("t1_credits_back", dut.credits_q, 16);

        // 2: credit stall with the consumer blocked
        p_ready = 0; starts = 0; pops = 0;
        push_job(1, 3, 5, 8);
        push_job(2, 3, 6, 8);
        push_job(3, 3, 7, 8);
        run(60);
        chk("t2_two_started", starts, 2);
        chk("t2_credits_zero", dut.credits_q, 0);
        p_ready = 100;
        for (int i = 0; i < 200 && pops < 8; i++) step();
        p_ready = 0;
        chk("t2_pops", pops, 8);
        run(30);
        chk("t2_third_started", starts, 3);
        p_ready = 100;
        wait_idle(300);

        // 3: engine held busy, job FIFO fills
        starts = 0; hold_busy = 1;
        for (int j = 1; j <= 5; j++) push_job(j, 1, j, 1);
        set_job(6, 1, 6, 1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_ready_low", bus.o_job_ready, 0);
            step();
        end
        chk("t3_one_started", starts, 1);
        hold_busy = 0;
        push_job(6, 1, 6, 1);
        wait_idle(300);
        chk("t3_all_started", starts, 6);

        // 4: illegal jobs are dropped
        starts = 0; errs = 0;
        push_job(0, 4, 0, 0);
        push_job(0, 4, 0, 17);
        run(6);
        chk("t4_errs", errs, 2);
        chk("t4_no_start", starts, 0);
        push_job(9, 5, 10, 3);
        run(8);
        chk("t4_legal_start", starts, 1);
        wait_idle(200);

        // 5: forced beats overflow a full result FIFO
        p_ready = 0; fv_cnt = 0; force_valid = 1;
        run(17);
        force_valid = 0;
        run(2);
        chk("t5_overflow", bus.o_overflow, 1);
        chk("t5_head", bus.o_res_data, {NL{32'd1}});
        chk("t5_model_count", rq.size(), 16);
        cnt5 = dut.res_wr_q - dut.res_rd_q;
        chk("t5_dut_count", cnt5, 16);
        p_ready = 100;
        run(20);
        chk("t5_credits_cap", dut.credits_q, 16);
        chk("t5_sticky", bus.o_overflow, 1);

        // 6: reset while running with results queued
        p_ready = 0;
        push_job(1, 2, 3, 8);
        for (int i = 0; i < 100 && !(rq.size() >= 5 && phase == 2); i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_res_valid", bus.o_res_valid, 0);
        chk("t6_credits", dut.credits_q, 16);
        chk("t6_idle", bus.o_idle, 1);
        chk("t6_job_ready", bus.o_job_ready, 1);
        chk("t6_overflow_clr", bus.o_overflow, 0);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(3))
                    0: p_ready = 100;
                    1: p_ready = 50;
                    2: p_ready = 15;
                    default: p_ready = 0;
                endcase
            end
            busy_dly = $urandom_range(2, 4);
            rst = ($urandom_range(999) == 0);
            if ($urandom_range(3) == 0) begin
                if ($urandom_range(9) == 0) set_job($urandom_range(255), $urandom_range(4), $urandom_range(511), $urandom_range(1) ? 0 : $urandom_range(17, 30));
                else set_job($urandom_range(255), $urandom_range(1, 256), $urandom_range(511), $urandom_range(1, 16));
            end else begin
                bus.i_job_valid = 1'b0;
            end
            step();
        end
        rst = 1'b0;
        bus.i_job_valid = 1'b0;
        p_ready = 100;
        wait_idle(2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
